// File: rtl/pipeline_pkg.sv
// rtl/pipeline_pkg.sv - shared widths and memory-access FSM encoding for the MEM/WB stage
package pipeline_pkg;

    localparam int DATA_W     = 32;
    localparam int REG_ADDR_W = 5;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_WAIT = 1'b1
    } mem_state_e;

endpackage

// File: rtl/mem_access_fsm.sv
// rtl/mem_access_fsm.sv - data-memory req/ack sequencing with wait-state timeout
module mem_access_fsm
    import pipeline_pkg::*;
#(
    parameter int MEM_TIMEOUT = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic access_valid,
    input  logic mem_ack,
    output logic mem_req,
    output logic stall,
    output logic abort
);

    localparam logic [7:0] LAST_COUNT = 8'(MEM_TIMEOUT - 1);

    mem_state_e state_q, state_d;
    logic [7:0] count_q, count_d;

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        // Abort drops the request so the stall releases in the same cycle.
        abort   = (state_q == ST_WAIT) && access_valid && !mem_ack && (count_q == LAST_COUNT);
        mem_req = access_valid && !abort;
        stall   = mem_req && !mem_ack;
        case (state_q)
            ST_IDLE: begin
                if (stall) begin
                    state_d = ST_WAIT;
                    count_d = 8'd1;
                end
            end
            ST_WAIT: begin
                if (!access_valid || mem_ack || abort) begin
                    state_d = ST_IDLE;
                    count_d = 8'd0;
                end else begin
                    count_d = count_q + 8'd1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                count_d = 8'd0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            count_q <= 8'd0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/mem_wb_stage.sv
// rtl/mem_wb_stage.sv - MIPS MEM stage: data access, branch resolve, MEM/WB register
module mem_wb_stage
    import pipeline_pkg::*;
#(
    parameter int DATA_W      = pipeline_pkg::DATA_W,
    parameter int MEM_TIMEOUT = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  regWriteFlagInput,
    input  logic                  memReadFlagInput,
    input  logic                  memWriteFlagInput,
    input  logic                  MemToRegInput,
    input  logic                  BranchsFlagInput,
    input  logic                  JumpsFlagInput,
    input  logic                  ZeroFlagInput,
    input  logic [DATA_W-1:0]     ResultInput,
    input  logic [DATA_W-1:0]     BInput,
    input  logic [DATA_W-1:0]     BranchAddressInput,
    input  logic [DATA_W-1:0]     JumpAddressInput,
    input  logic [REG_ADDR_W-1:0] regDestAddressInput,
    output logic                  memReqOutput,
    output logic                  memWeOutput,
    output logic [DATA_W-1:0]     memAddrOutput,
    output logic [DATA_W-1:0]     memWdataOutput,
    input  logic [DATA_W-1:0]     memRdataInput,
    input  logic                  memAckInput,
    output logic                  stallOutput,
    output logic                  pcSrcOutput,
    output logic [DATA_W-1:0]     pcTargetOutput,
    output logic                  regWriteFlagOutput,
    output logic                  MemToRegOutput,
    output logic [DATA_W-1:0]     readDataOutput,
    output logic [DATA_W-1:0]     ResultOutput,
    output logic [REG_ADDR_W-1:0] regDestAddressOutput,
    output logic                  memErrorOutput
);

    logic mem_op, misaligned, illegal, access_valid, abort;

    assign mem_op       = memReadFlagInput ^ memWriteFlagInput;
    assign misaligned   = mem_op && (ResultInput[1:0] != 2'b00);
    assign illegal      = (memReadFlagInput && memWriteFlagInput) || misaligned;
    assign access_valid = mem_op && !misaligned;

    mem_access_fsm #(
        .MEM_TIMEOUT (MEM_TIMEOUT)
    ) u_fsm (
        .clk          (clk),
        .reset        (reset),
        .access_valid (access_valid),
        .mem_ack      (memAckInput),
        .mem_req      (memReqOutput),
        .stall        (stallOutput),
        .abort        (abort)
    );

    assign memWeOutput    = memWriteFlagInput;
    assign memAddrOutput  = ResultInput;
    assign memWdataOutput = BInput;

    assign pcSrcOutput    = ((BranchsFlagInput && ZeroFlagInput) || JumpsFlagInput) && !stallOutput;
    assign pcTargetOutput = JumpsFlagInput ? JumpAddressInput : BranchAddressInput;

    logic                  reg_write_q, reg_write_d;
    logic                  mem_to_reg_q, mem_to_reg_d;
    logic [DATA_W-1:0]     read_data_q, read_data_d;
    logic [DATA_W-1:0]     result_q, result_d;
    logic [REG_ADDR_W-1:0] reg_dest_q, reg_dest_d;
    logic                  mem_error_q, mem_error_d;

    always_comb begin
        reg_write_d  = reg_write_q;
        mem_to_reg_d = mem_to_reg_q;
        read_data_d  = read_data_q;
        result_d     = result_q;
        reg_dest_d   = reg_dest_q;
        mem_error_d  = mem_error_q || abort || illegal;
        if (stallOutput) begin
            reg_write_d  = 1'b0;
            mem_to_reg_d = 1'b0;
        end else begin
            reg_write_d  = regWriteFlagInput && !abort && !illegal;
            mem_to_reg_d = MemToRegInput;
            result_d     = ResultInput;
            reg_dest_d   = regDestAddressInput;
            if (abort) begin
                read_data_d = '0;
            end else if (memReqOutput && memReadFlagInput && memAckInput) begin
                read_data_d = memRdataInput;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            reg_write_q  <= 1'b0;
            mem_to_reg_q <= 1'b0;
            read_data_q  <= '0;
            result_q     <= '0;
            reg_dest_q   <= '0;
            mem_error_q  <= 1'b0;
        end else begin
            reg_write_q  <= reg_write_d;
            mem_to_reg_q <= mem_to_reg_d;
            read_data_q  <= read_data_d;
            result_q     <= result_d;
            reg_dest_q   <= reg_dest_d;
            mem_error_q  <= mem_error_d;
        end
    end

    assign regWriteFlagOutput   = reg_write_q;
    assign MemToRegOutput       = mem_to_reg_q;
    assign readDataOutput       = read_data_q;
    assign ResultOutput         = result_q;
    assign regDestAddressOutput = reg_dest_q;
    assign memErrorOutput       = mem_error_q;

endmodule

// File: doc/mem_wb_stage.md
Name: mem_wb_stage

Overview:
- Consumer end of the EX/MEM pipeline register in the 5-stage MIPS pipeline.
- Takes the EX/MEM control and data fields, performs the load/store against data memory over a variable-latency req/ack handshake, resolves branch/jump, and registers the MEM/WB fields for writeback.
- Freezes the upstream stages with a stall while a memory access is outstanding.
- Aborts hung accesses with a timeout.

Parameters:
- DATA_W, 32, datapath/address width
- MEM_TIMEOUT, 16, max cycles an access may stall (issue cycle counted) before abort; legal range 2..255

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high reset
- regWriteFlagInput  in  1  EX/MEM RegWrite
- memReadFlagInput  in  1  EX/MEM MemRead
- memWriteFlagInput  in  1  EX/MEM MemWrite
- MemToRegInput  in  1  EX/MEM MemToReg
- BranchsFlagInput  in  1  EX/MEM Branch
- JumpsFlagInput  in  1  EX/MEM Jump
- ZeroFlagInput  in  1  EX/MEM ALU zero
- ResultInput  in  DATA_W  ALU result / memory address
- BInput  in  DATA_W  store data
- BranchAddressInput  in  DATA_W  branch target
- JumpAddressInput  in  DATA_W  jump target
- regDestAddressInput  in  5  destination register
- memReqOutput  out  1  data-memory request
- memWeOutput  out  1  1 = write, 0 = read
- memAddrOutput  out  DATA_W  = ResultInput
- memWdataOutput  out  DATA_W  = BInput
- memRdataInput  in  DATA_W  read data, valid with memAckInput
- memAckInput  in  1  access complete this cycle
- stallOutput  out  1  freeze PC/IF-ID/ID-EX/EX-MEM
- pcSrcOutput  out  1  redirect PC (branch taken or jump)
- pcTargetOutput  out  DATA_W  redirect target
- regWriteFlagOutput  out  1  MEM/WB RegWrite
- MemToRegOutput  out  1  MEM/WB MemToReg
- readDataOutput  out  DATA_W  MEM/WB load data
- ResultOutput  out  DATA_W  MEM/WB ALU result
- regDestAddressOutput  out  5  MEM/WB destination register
- memErrorOutput  out  1  sticky error (timeout, misaligned, or read+write)

Behaviour:
- Reset (synchronous): state=IDLE, count=0, all registered outputs 0, memErrorOutput=0. Reset wins over ack; any outstanding access is dropped.
- memOp = memReadFlagInput ^ memWriteFlagInput.
- Illegal access = both read and write flags set, or memOp with ResultInput[1:0]!=0.
  - No request is issued; memErrorOutput is set; the MEM/WB load is a bubble (regWriteFlagOutput=0); no stall.
- Combinational memory interface:
  - memReqOutput = legal memOp and not aborting.
  - memWeOutput = memWriteFlagInput.
  - stallOutput = memReqOutput & ~memAckInput.
- FSM states IDLE and WAIT:
  - IDLE: if memReq and no ack, go to WAIT with count=1. If memReq and ack arrive in the same cycle, the access completes with zero wait states.
  - WAIT: on ack, go to IDLE and complete. If no ack and count==MEM_TIMEOUT-1, abort: go to IDLE, set memErrorOutput, force stallOutput=0 that cycle, complete with readData=0 and regWrite=0. Otherwise count+1.
  - Stall therefore lasts at most MEM_TIMEOUT cycles including the issue cycle.
- MEM/WB register, loaded every cycle:
  - Stalled cycle: bubble. regWriteFlagOutput=0, MemToRegOutput=0, other fields hold.
  - Completed/non-memory cycle: regWriteFlagOutput=regWriteFlagInput (forced 0 on abort or illegal), MemToRegOutput, ResultOutput, regDestAddressOutput, readDataOutput=memRdataInput on read-ack, else hold.
- Latency: one cycle from completion (or non-mem op) to MEM/WB outputs.
- Control transfer:
  - pcSrcOutput = (BranchsFlagInput & ZeroFlagInput) | JumpsFlagInput, masked to 0 while stallOutput=1.
  - pcTargetOutput = Jump ? JumpAddressInput : BranchAddressInput.
  - Jump has priority over branch.
- Ignored inputs: an ack with no request is ignored; a late ack after an abort is ignored.
- memErrorOutput clears only on reset.

Decomposition:
- Shared package pipeline_pkg: DATA_W, REG_ADDR_W=5, FSM state encoding (IDLE=0, WAIT=1).
- One natural sub-module: mem_access_fsm (request/ack/timeout counter, generates stall/complete/abort). The MEM/WB register and branch logic stay in the top.

Test Plan:
- ALU op (regWrite=1, Result=0x00000010, rd=5, no mem) -> next cycle regWriteFlagOutput=1, ResultOutput=0x10, regDest=5, stall never asserted.
- Load addr 0x100, ack same cycle with rdata=0xDEADBEEF -> stall=0; next cycle readDataOutput=0xDEADBEEF, regWriteFlagOutput=1.
- Store addr 0x200 data 0x1234, ack on 3rd cycle -> stall high 2 cycles, memWe=1 throughout, MEM/WB shows 2 bubbles (regWrite=0), then completion.
- MEM_TIMEOUT=4, load with no ack -> stall high exactly 3 cycles, 4th cycle abort; memErrorOutput=1 sticky; regWrite=0; a late ack on cycle 6 has no effect.
- Load addr 0x102 -> memReqOutput never 1, memErrorOutput=1, bubble; next legal op proceeds normally.
- Reset asserted mid-WAIT -> next cycle state IDLE, all outputs 0, stall 0. Separately: Branch=1, Zero=1, target 0x40 -> pcSrcOutput=1, pcTargetOutput=0x40; with Jump=1 also set, target = JumpAddressInput.
